keypad_entry_ctrl: RTL and testbench

Sequencer that sits downstream of the teclado_matrix keypad scanner and turns raw key events into complete numeric entries. It consumes key_code/data_ready and accumulates up to DIGITS BCD digits. It handles backspace ('*'), enter ('#') and function keys (A-D), and aborts an entry after an inactivity timeout. A finished entry is presented to the consumer over a valid/ready handshake.

---
 rtl/keypad_entry_ctrl_pkg.sv | 31 +++
 rtl/keypad_entry_ctrl_entry_timer.sv | 43 ++++
 rtl/keypad_entry_ctrl.sv | 153 +++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_entry_ctrl_pkg.sv
// keypad_entry_ctrl_pkg
//   Shared definitions for the keypad entry sequencer: scanner key codes,
//   sequencer state encoding and small key-classification helpers.
package keypad_entry_ctrl_pkg;

   // Key codes delivered by the keypad scanner.
   localparam logic [3:0] KEY_A    = 4'hA;
   localparam logic [3:0] KEY_B    = 4'hB;
   localparam logic [3:0] KEY_C    = 4'hC;
   localparam logic [3:0] KEY_D    = 4'hD;
   localparam logic [3:0] KEY_STAR = 4'hE;  // backspace
   localparam logic [3:0] KEY_HASH = 4'hF;  // enter

   // Sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENTRY = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // True for the numeric keys 0-9.
   function automatic logic is_digit(input logic [3:0] key);
      return key <= 4'd9;
   endfunction

   // True for the function keys A-D.
   function automatic logic is_func(input logic [3:0] key);
      return (key >= KEY_A) && (key <= KEY_D);
   endfunction

endpackage

// File: rtl/keypad_entry_ctrl_entry_timer.sv
// entry_timer
//   Inactivity timer for an entry in progress. Counts enabled cycles that
//   are not cleared; expire pulses in the cycle the count sits at
//   TIMEOUT_CYCLES-1, so the owner can act on that same clock edge.
// Ports:
//   clock   in   system clock, rising edge
//   reset   in   asynchronous, active-high reset
//   enable  in   count while high; count is held at 0 while low
//   clear   in   restart the count (takes priority over expiry)
//   expire  out  combinational pulse, timer has run out this cycle
module entry_timer
   import keypad_entry_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic expire
);

   localparam int              CW   = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   // A clear in the expiry cycle suppresses the expiry: the key event wins.
   assign expire = enable && !clear && (cnt == LAST);

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear || !enable || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
//   Turns raw key strobes from the keypad scanner into complete numeric
//   entries of up to DIGITS BCD digits, with backspace ('*'), enter ('#'),
//   function keys (A-D) and an inactivity abort. A finished entry is held
//   for the consumer on a valid/ready handshake.
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   key_code     in   [3:0] 0-9 digit, A-D function, E '*', F '#'
//   data_ready   in   scanner strobe; rising edge marks one key event
//   value        out  [4*DIGITS-1:0] packed BCD, newest digit in [3:0]
//   count        out  [3:0] digits currently held
//   value_valid  out  entry complete and stable
//   value_ready  in   consumer accepts the entry (sampled in HOLD only)
//   cmd_code     out  [1:0] function key index, A=0 .. D=3
//   cmd_valid    out  one-cycle pulse, function key pressed
//   timeout      out  one-cycle pulse, entry aborted by inactivity
//   error        out  one-cycle pulse, key rejected
//   busy         out  high while an entry is in progress or held
module keypad_entry_ctrl
   import keypad_entry_ctrl_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [3:0]            key_code,
   input  logic                  data_ready,
   output logic [4*DIGITS-1:0]   value,
   output logic [3:0]            count,
   output logic                  value_valid,
   input  logic                  value_ready,
   output logic [1:0]            cmd_code,
   output logic                  cmd_valid,
   output logic                  timeout,
   output logic                  error,
   output logic                  busy
);

   localparam int         VW   = 4 * DIGITS;
   localparam logic [3:0] MAXC = 4'(DIGITS);

   state_t state;
   logic   ready_q;     // data_ready from the previous cycle
   logic   key_event;
   logic   expire;

   // Only the rising edge of the strobe counts, so a held key is one event.
   assign key_event = data_ready && !ready_q;

   entry_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clock  (clock),
      .reset  (reset),
      .enable (state == ENTRY),
      .clear  (key_event),
      .expire (expire)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         ready_q     <= 1'b0;
         value       <= '0;
         count       <= '0;
         value_valid <= 1'b0;
         cmd_code    <= '0;
         cmd_valid   <= 1'b0;
         timeout     <= 1'b0;
         error       <= 1'b0;
         busy        <= 1'b0;
      end else begin
         ready_q   <= data_ready;
         // Pulse outputs default low; a branch below raises one for a cycle.
         cmd_valid <= 1'b0;
         timeout   <= 1'b0;
         error     <= 1'b0;

         unique case (state)
            IDLE: begin
               if (key_event) begin
                  if (is_digit(key_code)) begin
                     value <= VW'(key_code);
                     count <= 4'd1;
                     state <= ENTRY;
                     busy  <= 1'b1;
                  end else if (is_func(key_code)) begin
                     cmd_valid <= 1'b1;
                     cmd_code  <= 2'(key_code - KEY_A);
                  end else if (key_code == KEY_HASH) begin
                     error <= 1'b1;   // nothing to enter
                  end
                  // '*' with nothing held is silently ignored.
               end
            end

            ENTRY: begin
               if (key_event) begin
                  if (is_digit(key_code)) begin
                     if (count == MAXC) begin
                        error <= 1'b1;
                     end else begin
                        value <= (value << 4) | VW'(key_code);
                        count <= count + 4'd1;
                     end
                  end else if (key_code == KEY_STAR) begin
                     value <= value >> 4;
                     count <= count - 4'd1;
                     if (count == 4'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else if (key_code == KEY_HASH) begin
                     state       <= HOLD;
                     value_valid <= 1'b1;
                  end else begin
                     cmd_valid <= 1'b1;
                     cmd_code  <= 2'(key_code - KEY_A);
                  end
               end else if (expire) begin
                  timeout <= 1'b1;
                  value   <= '0;
                  count   <= '0;
                  state   <= IDLE;
                  busy    <= 1'b0;
               end
            end

            HOLD: begin
               // Every key is refused while an entry waits for the consumer,
               // including in the cycle it is accepted.
               if (key_event) begin
                  error <= 1'b1;
               end
               if (value_ready) begin
                  value_valid <= 1'b0;
                  value       <= '0;
                  count       <= '0;
                  state       <= IDLE;
                  busy        <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl
//   Directed scenarios plus randomized key traffic for keypad_entry_ctrl.
//   The reference model keeps the entry as a queue of digits, a hold flag
//   and an idle-cycle count; all expected outputs are derived from those.
module tb_keypad_entry_ctrl;

   localparam int DIGITS = 4;
   localparam int TO     = 20;

   logic                 clock = 1'b0;
   logic                 reset;
   logic [3:0]           key_code;
   logic                 data_ready;
   logic [4*DIGITS-1:0]  value;
   logic [3:0]           count;
   logic                 value_valid;
   logic                 value_ready;
   logic [1:0]           cmd_code;
   logic                 cmd_valid;
   logic                 timeout;
   logic                 error;
   logic                 busy;

   keypad_entry_ctrl #(
      .DIGITS         (DIGITS),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .key_code    (key_code),
      .data_ready  (data_ready),
      .value       (value),
      .count       (count),
      .value_valid (value_valid),
      .value_ready (value_ready),
      .cmd_code    (cmd_code),
      .cmd_valid   (cmd_valid),
      .timeout     (timeout),
      .error       (error),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int         q[$];          // held digits, oldest first
   bit         m_hold;
   bit         m_dr_prev;
   int         m_idle;
   bit         e_cmd_valid, e_timeout, e_error;
   logic [1:0] e_cmd_code;

   task automatic model_reset();
      q.delete();
      m_hold      = 0;
      m_dr_prev   = 0;
      m_idle      = 0;
      e_cmd_valid = 0;
      e_timeout   = 0;
      e_error     = 0;
      e_cmd_code  = 2'd0;
   endtask

   function automatic logic [15:0] model_value();
      logic [15:0] v;
      v = 16'd0;
      foreach (q[i]) v = v * 16 + 16'(q[i]);
      return v;
   endfunction

   // Applies one clock edge to the model using the inputs present at it.
   task automatic model_step();
      bit ev;
      ev          = data_ready && !m_dr_prev;
      m_dr_prev   = data_ready;
      e_cmd_valid = 0;
      e_timeout   = 0;
      e_error     = 0;
      if (m_hold) begin
         if (ev) e_error = 1;
         if (value_ready) begin
            m_hold = 0;
            q.delete();
         end
      end else if (ev) begin
         m_idle = 0;
         if (key_code <= 4'd9) begin
            if (q.size() < DIGITS) q.push_back(int'(key_code));
            else e_error = 1;
         end else if (key_code == 4'hE) begin
            if (q.size() > 0) void'(q.pop_back());
         end else if (key_code == 4'hF) begin
            if (q.size() == 0) e_error = 1;
            else m_hold = 1;
         end else begin
            e_cmd_valid = 1;
            e_cmd_code  = 2'(key_code - 4'hA);
         end
      end else if (q.size() > 0) begin
         m_idle++;
         if (m_idle >= TO) begin
            e_timeout = 1;
            q.delete();
            m_idle = 0;
         end
      end else begin
         m_idle = 0;
      end
   endtask

   task automatic check_all();
      check("value",       32'(value),       32'(model_value()));
      check("count",       32'(count),       32'(q.size()));
      check("value_valid", 32'(value_valid), 32'(m_hold));
      check("busy",        32'(busy),        32'(m_hold || q.size() > 0));
      check("cmd_valid",   32'(cmd_valid),   32'(e_cmd_valid));
      check("cmd_code",    32'(cmd_code),    32'(e_cmd_code));
      check("timeout",     32'(timeout),     32'(e_timeout));
      check("error",       32'(error),       32'(e_error));
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
      check_all();
   endtask

   task automatic press(input logic [3:0] k);
      data_ready = 1'b1;
      key_code   = k;
      tick();
      data_ready = 1'b0;
      tick();
   endtask

   int cv_cnt;

   initial begin
      reset       = 1'b1;
      key_code    = 4'd0;
      data_ready  = 1'b0;
      value_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_all();
      reset = 1'b0;

      // 1: simple entry and handshake
      press(4'd1); press(4'd2); press(4'd3); press(4'hF);
      check("t1_value", 32'(value), 32'h0123);
      check("t1_count", 32'(count), 32'd3);
      check("t1_valid", 32'(value_valid), 32'd1);
      repeat (3) tick();
      value_ready = 1'b1; tick(); value_ready = 1'b0;
      check("t1_rel_valid", 32'(value_valid), 32'd0);
      check("t1_rel_busy",  32'(busy), 32'd0);

      // 2: overflow digit rejected
      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
      data_ready = 1'b1; key_code = 4'd5; tick();
      check("t2_error", 32'(error), 32'd1);
      check("t2_value", 32'(value), 32'h1234);
      data_ready = 1'b0; tick();
      press(4'hF);
      check("t2_held", 32'(value), 32'h1234);
      value_ready = 1'b1; tick(); value_ready = 1'b0;

      // 3: backspace to empty, then enter with nothing held
      press(4'd7); press(4'd8); press(4'hE);
      check("t3_value", 32'(value), 32'h0007);
      check("t3_count", 32'(count), 32'd1);
      press(4'hE);
      check("t3_busy", 32'(busy), 32'd0);
      data_ready = 1'b1; key_code = 4'hF; tick();
      check("t3_error", 32'(error), 32'd1);
      check("t3_valid", 32'(value_valid), 32'd0);
      data_ready = 1'b0; tick();

      // 4: inactivity timeout, then a key landing on the expiry edge
      data_ready = 1'b1; key_code = 4'd9; tick();
      data_ready = 1'b0;
      repeat (18) tick();
      tick();
      check("t4_early", 32'(timeout), 32'd0);
      tick();
      check("t4_timeout", 32'(timeout), 32'd1);
      check("t4_value",   32'(value), 32'd0);
      check("t4_busy",    32'(busy), 32'd0);
      data_ready = 1'b1; key_code = 4'd9; tick();
      data_ready = 1'b0;
      repeat (19) tick();
      data_ready = 1'b1; key_code = 4'd5; tick();
      check("t4_no_timeout", 32'(timeout), 32'd0);
      check("t4_value95",    32'(value), 32'h0095);
      data_ready = 1'b0; tick();
      press(4'hE); press(4'hE);

      // 5: held function key gives one command; rejected in HOLD
      press(4'd6);
      cv_cnt = 0;
      data_ready = 1'b1; key_code = 4'hB;
      repeat (3) begin tick(); cv_cnt += int'(cmd_valid); end
      data_ready = 1'b0; tick(); cv_cnt += int'(cmd_valid);
      check("t5_cmd_pulses", 32'(cv_cnt), 32'd1);
      check("t5_cmd_code",   32'(cmd_code), 32'd1);
      check("t5_value",      32'(value), 32'h0006);
      press(4'hF);
      data_ready = 1'b1; key_code = 4'hB; tick();
      check("t5_hold_err", 32'(error), 32'd1);
      check("t5_hold_cmd", 32'(cmd_valid), 32'd0);
      data_ready = 1'b0; value_ready = 1'b1; tick(); value_ready = 1'b0;

      // 6: asynchronous reset mid-entry
      press(4'd4); press(4'd2);
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("t6_value", 32'(value), 32'd0);
      check("t6_count", 32'(count), 32'd0);
      check("t6_busy",  32'(busy), 32'd0);
      check("t6_valid", 32'(value_valid), 32'd0);
      model_reset();
      #1 reset = 1'b0;
      press(4'd3);
      check("t6_value3", 32'(value), 32'h0003);
      check("t6_count1", 32'(count), 32'd1);

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 149) == 0) begin
            data_ready = 1'b0;
            repeat (TO + 3) tick();
         end
         if (data_ready) begin
            if ($urandom_range(0, 9) < 6) data_ready = 1'b0;
         end else if ($urandom_range(0, 9) < 3) begin
            int r;
            r = int'($urandom_range(0, 9));
            data_ready = 1'b1;
            if (r < 5)       key_code = 4'($urandom_range(0, 9));
            else if (r < 7)  key_code = 4'hE;
            else if (r == 7) key_code = 4'hF;
            else             key_code = 4'($urandom_range(10, 13));
         end
         value_ready = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
